xpb_accum: RTL and testbench
============================

# xpb_accum

Sequential accumulator that sits directly downstream of the registered XPB lookup tables in the modular-square reduction path. It consumes one precomputed 1024-bit XPB residue per accepted beat and sums the terms of one reduction in carry-save form, avoiding a full-width carry chain per beat. On the last term it resolves the redundant pair into a binary sum with a 64-bit chunked carry-propagate adder over several cycles. It then presents the result under a valid/ready handshake.

## Interface
- WIDTH, 1024, width of each XPB term (`in_data`)
- GUARD, 8, extra MSBs for growth; up to 2^GUARD-1 terms are exact
- CHUNK, 64, carry-propagate adder slice width used during resolve
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  `in_data` beat valid
- in_first  input  1  beat is the first term of a reduction
- in_last  input  1  beat is the last term (may coincide with `in_first`)
- in_data  input  WIDTH  XPB term, bits [WIDTH:1]
- in_ready  output  1  accumulator accepts a beat this cycle
- out_valid  output  1  `out_data` holds a resolved sum
- out_ready  input  1  downstream takes the result
- out_data  output  WIDTH+GUARD  binary sum of all terms, bits [WIDTH+GUARD:1]
- out_overflow  output  1  term count exceeded 2^GUARD-1; `out_data` not exact
- busy  output  1  state other than IDLE

## Operation
- Ports: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Internal registers: `sum_r` and `carry_r` (each WIDTH+GUARD bits), `cnt` (GUARD+1 bits, saturating), chunk index `k`, 1-bit chunk carry `cin`, result register.
- A beat is accepted when `in_valid & in_ready`.
- States:
  - IDLE: `in_ready`=1.
    - Accepted beat with `in_first` loads `sum_r`=zero-extended `in_data`, `carry_r`=0, `cnt`=1.
    - Then goes to RESOLVE if `in_last`, otherwise to ACC.
    - Accepted beat without `in_first` is dropped; state stays IDLE.
  - ACC: `in_ready`=1.
    - Accepted beat without `in_first` applies a 3:2 compressor: `sum_r`<=s^c^d; `carry_r`<=(s&c | s&d | c&d)<<1, truncated to WIDTH+GUARD bits; `cnt`++.
    - `in_last` moves to RESOLVE.
    - Accepted beat with `in_first` restarts: it reloads as in IDLE and discards the prior partial sum.
  - RESOLVE: `in_ready`=0. One chunk per cycle for k=0..NCH-1, where NCH=ceil((WIDTH+GUARD)/CHUNK)=17 at defaults.
    - result[k] = sum chunk + carry chunk + `cin`; carry-out goes to `cin`.
    - `cin`=0 at k=0.
    - The top chunk is partial (8 bits at defaults); its carry-out is discarded.
    - After chunk NCH-1, go to DONE.
  - DONE: `out_valid`=1, `in_ready`=0. `out_ready` moves to IDLE at the next edge.
- `out_overflow` is set when `cnt` would exceed 2^GUARD-1. It stays sticky until the next `in_first`. `cnt` saturates.
- Result is modulo 2^(WIDTH+GUARD). No modular reduction is done here; the next stage handles it.

## Timing
- Reset values: `out_valid`=0, `out_overflow`=0, `busy`=0, `out_data`=0, all internal registers 0, state IDLE.
- `in_ready`=0 while `reset_n` low; `in_ready`=1 in the first cycle after release.
- `in_ready`, `out_valid` and `busy` are decoded from state registers only; no combinational path from inputs.
- Throughput: one term per cycle in ACC.
- Latency:
  - Let E0 be the edge that accepts `in_last`.
  - RESOLVE occupies edges E1..E17; `out_valid` rises after E17 (17 cycles at defaults, NCH in general).
  - The handshake edge returns to IDLE; the earliest next `in_first` is accepted one cycle later.
- `out_data` and `out_overflow` stay stable while `out_valid` & !`out_ready`.
- `out_data` is only defined while `out_valid`.
- Reset mid-ACC or mid-RESOLVE aborts immediately. No `out_valid` pulse follows.
- `in_first` & `in_last` on one beat is a single-term reduction. Result equals the term zero-extended.

## Test plan
- Single term, `in_first`=`in_last`=1, `in_data`=1024'h9557…0619 -> `out_data`=same value zero-extended to 1032 bits; `out_valid` exactly 17 cycles after acceptance; `out_overflow`=0.
- Two terms, each 2^1024-1 -> `out_data`=1032'h1_FF…FE (2^1025-2); exercises carry into guard bits across all chunks.
- 32 random 1024-bit terms with random `in_valid` gaps -> `out_data` equals golden 1032-bit sum; `in_ready` drops during RESOLVE and DONE.
- Hold `out_ready`=0 for 5 cycles in DONE -> `out_data` stable, `in_valid` beats ignored; `out_ready`=1 -> IDLE next edge, new reduction accepted one cycle later.
- Three beats, then a new `in_first` beat with value 5, then `in_last` beat with value 7 -> `out_data`=12; beat without `in_first` in IDLE is dropped.
- 256 terms of value 1 -> `out_overflow`=1. Assert `reset_n` low during RESOLVE of a new reduction -> `out_valid`=0, no result emitted, `in_ready`=1 after release.

Source files
------------

// File: rtl/xpb_accum.sv
// rtl/xpb_accum.sv - carry-save accumulator of XPB terms with a chunked carry-propagate resolve
module xpb_accum #(
   parameter int WIDTH = 1024,
   parameter int GUARD = 8,
   parameter int CHUNK = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   input  logic                   in_first,
   input  logic                   in_last,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH+GUARD-1:0] out_data,
   output logic                   out_overflow,
   output logic                   busy
);
   localparam int WG  = WIDTH + GUARD;
   localparam int NCH = (WG + CHUNK - 1) / CHUNK;
   localparam int PW  = NCH * CHUNK;
   localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [GUARD:0] CMAX = {1'b0, {GUARD{1'b1}}};

   typedef enum logic [1:0] {IDLE, ACC, RESOLVE, DONE} state_t;

   state_t          state, state_n;
   logic [WG-1:0]   sum_r, carry_r, res_r;
   logic [GUARD:0]  cnt;
   logic            ovf_r;
   logic [KW-1:0]   k;
   logic            cin;
   logic            accept;
   logic [WG-1:0]   term, maj;
   logic [PW-1:0]   sum_pad, carry_pad;
   logic [CHUNK:0]  chunk_add;

   // reset_n gating keeps in_ready low while held in reset
   assign in_ready = reset_n & ((state == IDLE) | (state == ACC));
   assign accept   = in_valid & in_ready;

   assign term      = WG'(in_data);
   assign maj       = (sum_r & carry_r) | (sum_r & term) | (carry_r & term);
   assign sum_pad   = PW'(sum_r);
   assign carry_pad = PW'(carry_r);
   assign chunk_add = {1'b0, sum_pad[k*CHUNK +: CHUNK]}
                    + {1'b0, carry_pad[k*CHUNK +: CHUNK]}
                    + (CHUNK+1)'(cin);

   assign out_data     = res_r;
   assign out_overflow = ovf_r;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n   = state;
      out_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (accept && in_first) state_n = in_last ? RESOLVE : ACC;
         end
         ACC: begin
            if (accept && in_last) state_n = RESOLVE;
         end
         RESOLVE: begin
            if (k == KW'(NCH - 1)) state_n = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_r   <= '0;
         carry_r <= '0;
         res_r   <= '0;
         cnt     <= '0;
         ovf_r   <= 1'b0;
         k       <= '0;
         cin     <= 1'b0;
      end else begin
         case (state)
            IDLE, ACC: begin
               if (accept) begin
                  k   <= '0;
                  cin <= 1'b0;
                  if (in_first) begin
                     sum_r   <= term;
                     carry_r <= '0;
                     cnt     <= (GUARD+1)'(1);
                     ovf_r   <= 1'b0;
                  end else if (state == ACC) begin
                     sum_r   <= sum_r ^ carry_r ^ term;
                     carry_r <= maj << 1;
                     // count holds at its ceiling once the exact range is exceeded
                     if (cnt < CMAX) cnt <= cnt + 1'b1;
                     else            ovf_r <= 1'b1;
                  end
               end
            end
            RESOLVE: begin
               for (int i = 0; i < WG; i++) begin
                  if (i / CHUNK == int'(k)) res_r[i] <= chunk_add[i % CHUNK];
               end
               cin <= chunk_add[CHUNK];
               k   <= k + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_xpb_accum.sv
// tb/tb_xpb_accum.sv - scoreboard bench for xpb_accum
module tb_xpb_accum;
   localparam int W  = 1024;
   localparam int WG = 1032;

   logic          clk = 1'b0;
   logic          reset_n, in_valid, in_first, in_last, out_ready;
   logic [W-1:0]  in_data;
   logic          in_ready, out_valid, out_overflow, busy;
   logic [WG-1:0] out_data;

   int errors = 0;
   int checks = 0;
   logic [WG-1:0] exp_d_q[$];
   logic          exp_o_q[$];

   always #5 clk = ~clk;

   xpb_accum dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_overflow(out_overflow), .busy(busy)
   );

   task automatic beat(input logic f, input logic l, input logic [W-1:0] d);
      int n = 0;
      in_valid = 1'b1; in_first = f; in_last = l; in_data = d;
      while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL beat_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
      end
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
   endtask

   task automatic get_result(input int want_lat);
      int n = 0;
      logic [WG-1:0] ed;
      logic          eo;
      logic [1087:0] pa, pe;
      while (out_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL result_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
         return;
      end
      if (want_lat >= 0) begin
         checks++;
         if (n != want_lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required %0d", n, want_lat);
         end
      end
      checks++;
      if (exp_d_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_result: queue empty, got out_valid=1");
      end else begin
         ed = exp_d_q.pop_front();
         eo = exp_o_q.pop_front();
         checks++;
         if (out_data !== ed) begin
            errors++;
            pa = 1088'(out_data);
            pe = 1088'(ed);
            for (int c = 0; c < 17; c++) begin
               if (pa[c*64 +: 64] !== pe[c*64 +: 64]) begin
                  $display("FAIL out_data: chunk %0d got %h, required %h", c, pa[c*64 +: 64], pe[c*64 +: 64]);
                  break;
               end
            end
         end
         checks++;
         if (out_overflow !== eo) begin
            errors++;
            $display("FAIL out_overflow: got %b, required %b", out_overflow, eo);
         end
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL in_ready_done: got %b, required 0", in_ready);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL return_idle: busy=%b in_ready=%b, required 0 and 1", busy, in_ready);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 0 0 0", in_ready, out_valid, busy);
      end
      checks++;
      if (out_overflow !== 1'b0 || out_data !== '0) begin
         errors++;
         $display("FAIL reset_data: out_overflow=%b out_data_lo=%h, required 0 and 0", out_overflow, out_data[63:0]);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
      end
   endtask

   task automatic test_single();
      logic [W-1:0] d;
      d = {16'h9557, {62{16'hA5C3}}, 16'h0619};
      exp_d_q.push_back(WG'(d)); exp_o_q.push_back(1'b0);
      beat(1'b1, 1'b1, d);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_resolve: in_ready=%b busy=%b, required 0 1", in_ready, busy);
      end
      get_result(17);
   endtask

   task automatic test_two_max();
      logic [W-1:0] ones;
      ones = '1;
      exp_d_q.push_back(WG'(ones) + WG'(ones)); exp_o_q.push_back(1'b0);
      beat(1'b1, 1'b0, ones);
      beat(1'b0, 1'b1, ones);
      get_result(17);
   endtask

   task automatic test_random();
      logic [W-1:0]  d;
      logic [WG-1:0] s;
      s = '0;
      for (int i = 0; i < 32; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         for (int j = 0; j < 32; j++) d[j*32 +: 32] = $urandom;
         s = s + WG'(d);
         if (i == 31) begin exp_d_q.push_back(s); exp_o_q.push_back(1'b0); end
         beat(i == 0, i == 31, d);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL random_resolve: in_ready=%b busy=%b, required 0 1", in_ready, busy);
      end
      get_result(17);
   endtask

   task automatic test_hold();
      logic [W-1:0]  d;
      logic [WG-1:0] ed;
      logic          eo;
      int n = 0;
      for (int j = 0; j < 32; j++) d[j*32 +: 32] = $urandom;
      exp_d_q.push_back(WG'(d)); exp_o_q.push_back(1'b0);
      beat(1'b1, 1'b1, d);
      while (out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      ed = exp_d_q.pop_front();
      eo = exp_o_q.pop_front();
      in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_data = ~d;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== ed || out_overflow !== eo || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_stable: cycle %0d out_valid=%b in_ready=%b data_lo=%h, required 1 0 %h",
                     c, out_valid, in_ready, out_data[63:0], ed[63:0]);
         end
         @(negedge clk);
      end
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_release: busy=%b in_ready=%b out_valid=%b, required 0 1 0", busy, in_ready, out_valid);
      end
      exp_d_q.push_back(WG'(3)); exp_o_q.push_back(1'b0);
      beat(1'b1, 1'b1, W'(3));
      get_result(17);
   endtask

   task automatic test_restart();
      beat(1'b0, 1'b1, W'(99));
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_drop: busy=%b, required 0", busy);
      end
      exp_d_q.push_back(WG'(12)); exp_o_q.push_back(1'b0);
      beat(1'b1, 1'b0, W'(100));
      beat(1'b0, 1'b0, W'(200));
      beat(1'b0, 1'b0, W'(300));
      beat(1'b1, 1'b0, W'(5));
      beat(1'b0, 1'b1, W'(7));
      get_result(17);
   endtask

   task automatic test_overflow();
      exp_d_q.push_back(WG'(256)); exp_o_q.push_back(1'b1);
      for (int i = 0; i < 256; i++) beat(i == 0, i == 255, W'(1));
      get_result(-1);
      exp_d_q.push_back(WG'(255)); exp_o_q.push_back(1'b0);
      for (int i = 0; i < 255; i++) beat(i == 0, i == 254, W'(1));
      get_result(-1);
   endtask

   task automatic test_reset_resolve();
      logic seen = 1'b0;
      beat(1'b1, 1'b1, W'(42));
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: busy=%b, required 1", busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset: out_valid=%b busy=%b in_ready=%b, required 0 0 0", out_valid, busy, in_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_release: in_ready=%b, required 1", in_ready);
      end
      for (int c = 0; c < 30; c++) begin
         if (out_valid === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_output: out_valid seen=%b, required 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_max();
      test_random();
      test_hold();
      test_restart();
      test_overflow();
      test_reset_resolve();
      checks++;
      if (exp_d_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_d_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
